// File: rtl/sync_bcd_down_counter.sv
// ----------------------------------------------------------------------------
// sync_bcd_down_counter
//   Synchronous, loadable, multi-digit BCD down-counter with a cascadable
//   borrow output and a zero flag. Every digit is clocked by the same Clk.
//   The borrow between digits is combinational, so the whole value steps
//   by exactly one on each enabled edge.
//
// Parameters
//   DIGITS : number of BCD digits (1..4); digit 0 is the least significant
//   WRAP   : 1 = all-zero wraps to all-nines, 0 = saturate at all-zero
//
// Ports
//   Clk   : clock; all state updates happen on the rising edge
//   Rst_b : asynchronous active-low reset; clears Q
//   En    : count enable; decrement on the next rising edge
//   Ld    : synchronous load strobe; has priority over En
//   D     : load value, 4 bits per digit, digit 0 in D[3:0]
//   Q     : registered counter value, packed like D
//   Zero  : Q is all zeros (depends on Q only)
//   Bout  : borrow out, En & ~Ld & (Q == 0); drives En of an upper stage
// ----------------------------------------------------------------------------

// One BCD digit: holds its 4-bit value, loads with clamping and steps down
// by one when told to. The decision to step comes from the borrow chain
// in the parent.
module sync_bcd_down_digit (
   input  logic       Clk,
   input  logic       Rst_b,
   input  logic       ld,
   input  logic       step,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       at_zero
);

   logic [3:0] d_clamped;

   // Nibbles A..F cannot be represented as a digit; store them as 9.
   assign d_clamped = (d > 4'd9) ? 4'd9 : d;
   assign at_zero   = (q == 4'd0);

   always_ff @(posedge Clk or negedge Rst_b) begin
      if (!Rst_b) begin
         q <= 4'd0;
      end else if (ld) begin
         q <= d_clamped;
      end else if (step) begin
         q <= at_zero ? 4'd9 : q - 4'd1;
      end
   end

endmodule

module sync_bcd_down_counter #(
   parameter int DIGITS = 2,
   parameter bit WRAP   = 1'b1
) (
   input  logic                  Clk,
   input  logic                  Rst_b,
   input  logic                  En,
   input  logic                  Ld,
   input  logic [4*DIGITS-1:0]   D,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  Zero,
   output logic                  Bout
);

   logic [DIGITS-1:0][3:0] d_dig;
   logic [DIGITS-1:0][3:0] q_dig;
   logic [DIGITS-1:0]      at_zero;
   logic [DIGITS-1:0]      borrow;
   logic [DIGITS-1:0]      step;
   logic                   dec_en;

   assign d_dig = D;
   assign Q     = q_dig;
   assign Zero  = &at_zero;
   assign Bout  = En & ~Ld & Zero;

   // A decrement is requested when enabled and not loading. In saturating
   // mode the all-zero state simply refuses to step, while Bout still
   // reports the underflow to any upper stage.
   assign dec_en = En & ~Ld & (WRAP | ~Zero);

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_digit
         // Digit 0 always takes the borrow; each higher digit takes it only
         // when every digit below is at zero (and will roll over to 9).
         if (i == 0) begin : g_lsd
            assign borrow[i] = 1'b1;
         end else begin : g_upper
            assign borrow[i] = borrow[i-1] & at_zero[i-1];
         end

         assign step[i] = dec_en & borrow[i];

         sync_bcd_down_digit u_digit (
            .Clk     (Clk),
            .Rst_b   (Rst_b),
            .ld      (Ld),
            .step    (step[i]),
            .d       (d_dig[i]),
            .q       (q_dig[i]),
            .at_zero (at_zero[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_sync_bcd_down_counter.sv
// ----------------------------------------------------------------------------
// tb_sync_bcd_down_counter
//   Directed bench for sync_bcd_down_counter. Instances:
//     u_wrap : DIGITS=2, WRAP=1
//     u_sat  : DIGITS=2, WRAP=0
//     u_lo / u_hi : two DIGITS=1 stages cascaded through Bout -> En
//   Inputs change on the falling edge; registered outputs are sampled 1 ns
//   after the rising edge, combinational flags just after the input change.
// ----------------------------------------------------------------------------
module tb_sync_bcd_down_counter;

   logic       Clk;
   logic       Rst_b;

   logic       en_w, ld_w;
   logic [7:0] d_w, q_w;
   logic       zero_w, bout_w;

   logic       en_s, ld_s;
   logic [7:0] d_s, q_s;
   logic       zero_s, bout_s;

   logic       cas_en, cas_ld;
   logic [3:0] d_lo, d_hi, q_lo, q_hi;
   logic       zero_lo, zero_hi, bout_lo, bout_hi;

   int checks = 0;
   int errors = 0;

   sync_bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
      .Clk(Clk), .Rst_b(Rst_b), .En(en_w), .Ld(ld_w), .D(d_w),
      .Q(q_w), .Zero(zero_w), .Bout(bout_w));

   sync_bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat (
      .Clk(Clk), .Rst_b(Rst_b), .En(en_s), .Ld(ld_s), .D(d_s),
      .Q(q_s), .Zero(zero_s), .Bout(bout_s));

   sync_bcd_down_counter #(.DIGITS(1), .WRAP(1'b1)) u_lo (
      .Clk(Clk), .Rst_b(Rst_b), .En(cas_en), .Ld(cas_ld), .D(d_lo),
      .Q(q_lo), .Zero(zero_lo), .Bout(bout_lo));

   sync_bcd_down_counter #(.DIGITS(1), .WRAP(1'b1)) u_hi (
      .Clk(Clk), .Rst_b(Rst_b), .En(bout_lo), .Ld(cas_ld), .D(d_hi),
      .Q(q_hi), .Zero(zero_hi), .Bout(bout_hi));

   // Rising edges at 10, 20, ...; falling edges at 5, 15, ...
   initial Clk = 1'b1;
   always #5 Clk = ~Clk;

   // Decimal 0..99 to two packed BCD digits.
   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] tens, ones;
      tens = 4'(v / 10);
      ones = 4'(v % 10);
      return {tens, ones};
   endfunction

   // Load one value into u_wrap on the next rising edge.
   task automatic load_w(input logic [7:0] val);
      @(negedge Clk);
      ld_w = 1'b1; en_w = 1'b0; d_w = val;
      @(posedge Clk); #1;
      ld_w = 1'b0;
   endtask

   task automatic test_reset;
      Rst_b = 1'b0;
      en_w = 1'b0; ld_w = 1'b0; d_w = 8'h00;
      en_s = 1'b0; ld_s = 1'b0; d_s = 8'h00;
      cas_en = 1'b0; cas_ld = 1'b0; d_lo = 4'h0; d_hi = 4'h0;
      #2;
      checks++;
      if (q_w !== 8'h00) begin errors++; $display("FAIL reset_q_w got %h want 00", q_w); end
      checks++;
      if (zero_w !== 1'b1) begin errors++; $display("FAIL reset_zero_w got %b want 1", zero_w); end
      checks++;
      if (q_s !== 8'h00) begin errors++; $display("FAIL reset_q_s got %h want 00", q_s); end
      checks++;
      if (bout_w !== 1'b0) begin errors++; $display("FAIL reset_bout_en0 got %b want 0", bout_w); end
      en_w = 1'b1;
      #1;
      checks++;
      if (bout_w !== 1'b1) begin errors++; $display("FAIL reset_bout_en1 got %b want 1", bout_w); end
      en_w = 1'b0;
      #2;
      Rst_b = 1'b1;   // released at 5 ns, on a falling edge
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if (q_w !== 8'h00) begin errors++; $display("FAIL post_release_q got %h want 00", q_w); end
      checks++;
      if (zero_w !== 1'b1) begin errors++; $display("FAIL post_release_zero got %b want 1", zero_w); end
   endtask

   task automatic test_reset_mid_count;
      load_w(8'h48);
      @(negedge Clk);
      en_w = 1'b1;
      @(posedge Clk); #1;
      checks++;
      if (q_w !== 8'h47) begin errors++; $display("FAIL midreset_pre got %h want 47", q_w); end
      Rst_b = 1'b0;
      #1;
      checks++;
      if (q_w !== 8'h00) begin errors++; $display("FAIL midreset_clear got %h want 00", q_w); end
      #2;
      Rst_b = 1'b1;
      @(negedge Clk);
      en_w = 1'b0;
      @(posedge Clk); #1;
      checks++;
      if (q_w !== 8'h00) begin errors++; $display("FAIL midreset_after got %h want 00", q_w); end
   endtask

   task automatic test_load_count;
      int exp_v;
      load_w(8'h12);
      checks++;
      if (q_w !== 8'h12) begin errors++; $display("FAIL load_12 got %h want 12", q_w); end
      exp_v = 12;
      for (int i = 0; i < 13; i++) begin
         @(negedge Clk);
         en_w = 1'b1;
         #1;
         checks++;
         if (zero_w !== (exp_v == 0)) begin
            errors++; $display("FAIL count_zero step %0d got %b want %b", i, zero_w, exp_v == 0);
         end
         checks++;
         if (bout_w !== (exp_v == 0)) begin
            errors++; $display("FAIL count_bout step %0d got %b want %b", i, bout_w, exp_v == 0);
         end
         @(posedge Clk); #1;
         exp_v = (exp_v == 0) ? 99 : exp_v - 1;
         checks++;
         if (q_w !== to_bcd(exp_v)) begin
            errors++; $display("FAIL count_q step %0d got %h want %h", i, q_w, to_bcd(exp_v));
         end
      end
      @(negedge Clk);
      en_w = 1'b0;
   endtask

   task automatic test_borrow;
      load_w(8'h50);
      @(negedge Clk);
      en_w = 1'b1;
      @(posedge Clk); #1;
      en_w = 1'b0;
      checks++;
      if (q_w !== 8'h49) begin errors++; $display("FAIL borrow_50 got %h want 49", q_w); end

      load_w(8'h00);
      @(negedge Clk);
      en_w = 1'b1;
      #1;
      checks++;
      if (bout_w !== 1'b1) begin errors++; $display("FAIL wrap_bout got %b want 1", bout_w); end
      @(posedge Clk); #1;
      en_w = 1'b0;
      checks++;
      if (q_w !== 8'h99) begin errors++; $display("FAIL wrap_00 got %h want 99", q_w); end
   endtask

   task automatic test_saturate;
      logic [7:0] exp_q  [3] = '{8'h00, 8'h00, 8'h00};
      logic       exp_bo [3] = '{1'b0, 1'b1, 1'b1};
      @(negedge Clk);
      ld_s = 1'b1; d_s = 8'h01;
      @(posedge Clk); #1;
      ld_s = 1'b0;
      checks++;
      if (q_s !== 8'h01) begin errors++; $display("FAIL sat_load got %h want 01", q_s); end
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         en_s = 1'b1;
         #1;
         checks++;
         if (bout_s !== exp_bo[i]) begin
            errors++; $display("FAIL sat_bout step %0d got %b want %b", i, bout_s, exp_bo[i]);
         end
         @(posedge Clk); #1;
         checks++;
         if (q_s !== exp_q[i]) begin
            errors++; $display("FAIL sat_q step %0d got %h want %h", i, q_s, exp_q[i]);
         end
      end
      checks++;
      if (bout_s !== 1'b1) begin errors++; $display("FAIL sat_bout_hold got %b want 1", bout_s); end
      @(negedge Clk);
      en_s = 1'b0;
      #1;
      checks++;
      if (bout_s !== 1'b0) begin errors++; $display("FAIL sat_bout_idle got %b want 0", bout_s); end
   endtask

   task automatic test_priority_clamp;
      load_w(8'h00);
      @(negedge Clk);
      ld_w = 1'b1; en_w = 1'b1; d_w = 8'hAF;
      #1;
      checks++;
      if (bout_w !== 1'b0) begin errors++; $display("FAIL prio_bout got %b want 0", bout_w); end
      @(posedge Clk); #1;
      checks++;
      if (q_w !== 8'h99) begin errors++; $display("FAIL prio_clamp_AF got %h want 99", q_w); end

      @(negedge Clk);
      ld_w = 1'b1; en_w = 1'b0; d_w = 8'h3C;
      @(posedge Clk); #1;
      checks++;
      if (q_w !== 8'h39) begin errors++; $display("FAIL clamp_3C got %h want 39", q_w); end

      @(negedge Clk);
      ld_w = 1'b0; en_w = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge Clk); #1;
         checks++;
         if (q_w !== 8'h39 || bout_w !== 1'b0) begin
            errors++; $display("FAIL hold step %0d got %h/%b want 39/0", i, q_w, bout_w);
         end
      end
   endtask

   task automatic test_cascade;
      int exp_v;
      @(negedge Clk);
      cas_ld = 1'b1; d_hi = 4'd3; d_lo = 4'd0;
      @(posedge Clk); #1;
      cas_ld = 1'b0;
      checks++;
      if ({q_hi, q_lo} !== 8'h30) begin
         errors++; $display("FAIL cascade_load got %h want 30", {q_hi, q_lo});
      end
      exp_v = 30;
      @(negedge Clk);
      cas_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clk); #1;
         exp_v = (exp_v == 0) ? 99 : exp_v - 1;
         checks++;
         if ({q_hi, q_lo} !== to_bcd(exp_v)) begin
            errors++; $display("FAIL cascade step %0d got %h want %h", i, {q_hi, q_lo}, to_bcd(exp_v));
         end
      end
      @(negedge Clk);
      cas_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_mid_count();
      test_load_count();
      test_borrow();
      test_saturate();
      test_priority_clamp();
      test_cascade();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
